// File: rtl/piso_shift_register_jk.sv
// Parallel-in serial-out shift register with a valid/ready load handshake.
// A word is accepted in IDLE or during the last bit of the previous word, so words can stream with no gap.
module piso_shift_register_jk #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] rest_bits;
  logic [WIDTH-1:0] sr_shifted;

  // The shift register holds the bits still to be sent, aligned so the next one sits at the exit end.
  always_comb begin
    if (MSB_FIRST) begin
      first_bit  = data_in[WIDTH-1];
      rest_bits  = data_in << 1;
      next_bit   = sr_q[WIDTH-1];
      sr_shifted = sr_q << 1;
    end else begin
      first_bit  = data_in[0];
      rest_bits  = data_in >> 1;
      next_bit   = sr_q[0];
      sr_shifted = sr_q >> 1;
    end
  end

  assign last_bit   = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    done_d  = done_q;

    unique case (state_q)
      IDLE: begin
        out_d   = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
      SHIFT: begin
        if (!last_bit) begin
          out_d  = next_bit;
          sr_d   = sr_shifted;
          cnt_d  = cnt_q - CNT_W'(1);
          done_d = (cnt_q == CNT_W'(1));
        end else begin
          state_d = IDLE;
          sr_d    = '0;
          out_d   = 1'b0;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides the drain/return path so the next word follows the last bit directly.
    if (accept) begin
      state_d = SHIFT;
      out_d   = first_bit;
      valid_d = 1'b1;
      done_d  = 1'b0;
      sr_d    = rest_bits;
      cnt_d   = CNT_W'(WIDTH - 1);
    end
  end

  // NOTE: all state, including the data shift register, is reset so an aborted word leaves no residue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign serial_out   = out_q;
  assign serial_valid = valid_q;
  assign done         = done_q;

endmodule

// File: tb/tb_piso_shift_register_jk.sv
// Bench for piso_shift_register_jk: an MSB-first and an LSB-first instance share stimulus.
// Directed scenarios plus random words rebuilt by a serial-in parallel-out receiver.
module tb_piso_shift_register_jk;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] data_in = '0;

  logic lr_m, so_m, v_m, d_m;
  logic lr_l, so_l, v_l, d_l;

  int n_checks = 0;
  int n_errors = 0;

  piso_shift_register_jk #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(load_valid), .data_in(data_in),
    .load_ready(lr_m), .serial_out(so_m), .serial_valid(v_m), .done(d_m)
  );

  piso_shift_register_jk #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(load_valid), .data_in(data_in),
    .load_ready(lr_l), .serial_out(so_l), .serial_valid(v_l), .done(d_l)
  );

  always #5 clk = ~clk;

  // Serial-in parallel-out receivers: shift in each valid bit mid-cycle, emit a word on done.
  logic [W-1:0] rx_m = '0, rx_l = '0;
  logic [W-1:0] q_m[$];
  logic [W-1:0] q_l[$];

  always @(negedge clk) begin
    if (rst && v_m) begin
      rx_m = {rx_m[W-2:0], so_m};
      if (d_m) q_m.push_back(rx_m);
    end
  end

  always @(negedge clk) begin
    if (rst && v_l) begin
      rx_l = {so_l, rx_l[W-1:1]};
      if (d_l) q_l.push_back(rx_l);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    n_checks++;
    if ({v_m, so_m, d_m, lr_m} !== 4'b0001) begin
      n_errors++;
      $display("FAIL %s msb idle {valid,out,done,ready} got %b want 0001", tag, {v_m, so_m, d_m, lr_m});
    end
    n_checks++;
    if ({v_l, so_l, d_l, lr_l} !== 4'b0001) begin
      n_errors++;
      $display("FAIL %s lsb idle {valid,out,done,ready} got %b want 0001", tag, {v_l, so_l, d_l, lr_l});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    check_idle("reset_async");
    step();
    check_idle("reset_held");
    #2 rst = 1'b1;
    step();
    check_idle("reset_release");
  endtask

  task automatic test_single_word();
    logic [W-1:0] w = 4'b1011;
    load_valid = 1'b1;
    data_in    = w;
    n_checks++;
    if ({lr_m, lr_l} !== 2'b11) begin
      n_errors++;
      $display("FAIL single_ready_idle got %b want 11", {lr_m, lr_l});
    end
    step();
    load_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      n_checks++;
      if ({v_m, so_m, d_m, lr_m} !== {1'b1, w[W-1-k], k == W - 1, k == W - 1}) begin
        n_errors++;
        $display("FAIL single_msb bit%0d {valid,out,done,ready} got %b want %b", k,
                 {v_m, so_m, d_m, lr_m}, {1'b1, w[W-1-k], k == W - 1, k == W - 1});
      end
      n_checks++;
      if ({v_l, so_l, d_l, lr_l} !== {1'b1, w[k], k == W - 1, k == W - 1}) begin
        n_errors++;
        $display("FAIL single_lsb bit%0d {valid,out,done,ready} got %b want %b", k,
                 {v_l, so_l, d_l, lr_l}, {1'b1, w[k], k == W - 1, k == W - 1});
      end
      step();
    end
    check_idle("single_after");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w0 = 4'b1100;
    logic [W-1:0] w1 = 4'b0011;
    logic [2*W-1:0] s_m, s_l;
    s_m = {w0, w1};
    for (int i = 0; i < W; i++) begin
      s_l[2*W-1-i] = w0[i];
      s_l[W-1-i]   = w1[i];
    end
    load_valid = 1'b1;
    data_in    = w0;
    step();
    data_in = w1;
    for (int k = 0; k < 2 * W; k++) begin
      if (k == W) load_valid = 1'b0;
      n_checks++;
      if ({v_m, so_m, d_m} !== {1'b1, s_m[2*W-1-k], (k % W) == W - 1}) begin
        n_errors++;
        $display("FAIL b2b_msb bit%0d {valid,out,done} got %b want %b", k,
                 {v_m, so_m, d_m}, {1'b1, s_m[2*W-1-k], (k % W) == W - 1});
      end
      n_checks++;
      if ({v_l, so_l, d_l} !== {1'b1, s_l[2*W-1-k], (k % W) == W - 1}) begin
        n_errors++;
        $display("FAIL b2b_lsb bit%0d {valid,out,done} got %b want %b", k,
                 {v_l, so_l, d_l}, {1'b1, s_l[2*W-1-k], (k % W) == W - 1});
      end
      step();
    end
    check_idle("b2b_after");
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] w = 4'b1001;
    load_valid = 1'b1;
    data_in    = w;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      n_checks++;
      if ({v_m, so_m, v_l, so_l} !== {1'b1, w[W-1-k], 1'b1, w[k]}) begin
        n_errors++;
        $display("FAIL busy bit%0d {vm,om,vl,ol} got %b want %b", k,
                 {v_m, so_m, v_l, so_l}, {1'b1, w[W-1-k], 1'b1, w[k]});
      end
      if (k == 1) begin
        load_valid = 1'b1;
        data_in    = 4'b0110;
      end
      if (k == 2) load_valid = 1'b0;
      step();
    end
    for (int k = 0; k < 3; k++) check_idle("busy_after");
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w = 4'b0110;
    load_valid = 1'b1;
    data_in    = 4'b1111;
    step();
    load_valid = 1'b0;
    step();
    n_checks++;
    if ({v_m, so_m, v_l, so_l} !== 4'b1111) begin
      n_errors++;
      $display("FAIL rstmid second_bit got %b want 1111", {v_m, so_m, v_l, so_l});
    end
    #2 rst = 1'b0;
    #1;
    check_idle("rstmid_async");
    #2 rst = 1'b1;
    for (int k = 0; k < W; k++) begin
      step();
      check_idle("rstmid_no_resume");
    end
    // Release between edges, then the very next edge must accept.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    load_valid = 1'b1;
    data_in    = w;
    step();
    load_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      n_checks++;
      if ({v_m, so_m, d_m, v_l, so_l, d_l} !==
          {1'b1, w[W-1-k], k == W - 1, 1'b1, w[k], k == W - 1}) begin
        n_errors++;
        $display("FAIL rstmid_reaccept bit%0d got %b want %b", k, {v_m, so_m, d_m, v_l, so_l, d_l},
                 {1'b1, w[W-1-k], k == W - 1, 1'b1, w[k], k == W - 1});
      end
      step();
    end
    check_idle("rstmid_after");
  endtask

  task automatic test_random_words();
    logic [W-1:0] words[16];
    int base_m, base_l, waited, gap;
    logic took;
    base_m = q_m.size();
    base_l = q_l.size();
    for (int i = 0; i < 16; i++) begin
      words[i]   = W'($urandom);
      load_valid = 1'b1;
      data_in    = words[i];
      waited     = 0;
      took       = 1'b0;
      while (!took && waited <= 20) begin
        took = lr_m;
        step();
        waited++;
      end
      n_checks++;
      if (!took) begin
        n_errors++;
        $display("FAIL random accept word%0d got no accept want accept within 20 cycles", i);
      end
      load_valid = 1'b0;
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        data_in = W'($urandom);
        step();
      end
    end
    load_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      data_in = W'($urandom);
      if (q_m.size() >= base_m + 16 && q_l.size() >= base_l + 16) break;
      step();
    end
    n_checks++;
    if (q_m.size() != base_m + 16 || q_l.size() != base_l + 16) begin
      n_errors++;
      $display("FAIL random count got msb %0d lsb %0d want 16 each", q_m.size() - base_m, q_l.size() - base_l);
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (q_m[base_m+i] !== words[i]) begin
          n_errors++;
          $display("FAIL random msb word%0d got %b want %b", i, q_m[base_m+i], words[i]);
        end
        n_checks++;
        if (q_l[base_l+i] !== words[i]) begin
          n_errors++;
          $display("FAIL random lsb word%0d got %b want %b", i, q_l[base_l+i], words[i]);
        end
      end
    end
    check_idle("random_after");
  endtask

  initial begin
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_word();
    test_random_words();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
